// File: rtl/atomic_counter_pkg.sv
// Shared definitions for the atomic 64-bit statistics counter.
//   CNT_W : width of the free-running event counter
//   BUS_W : width of one read beat on the host bus
//   cnt_t : full counter value
//   bus_t : one bus word
package atomic_counter_pkg;

    localparam int unsigned CNT_W = 64;
    localparam int unsigned BUS_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [BUS_W-1:0] bus_t;

endpackage

// File: rtl/atomic_counter.sv
// Free-running 64-bit event counter read over a 32-bit bus in two beats.
// An atomic beat returns the low word and snapshots the high word into a shadow
// register in the same cycle; the following upper beat returns the shadow, so the
// host always sees a coherent 64-bit value while counting continues.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active low
//   trig_i   : count enable, +1 per cycle while high
//   req_i    : read request, one beat per cycle while high
//   atomic_i : 1 = low word + high-word snapshot, 0 = read shadow
//   ack_o    : registered acknowledge, count_o valid while high
//   count_o  : read data
module atomic_counter #(
    parameter int unsigned CNT_W = atomic_counter_pkg::CNT_W,
    parameter int unsigned BUS_W = atomic_counter_pkg::BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_i,
    input  logic             req_i,
    input  logic             atomic_i,
    output logic             ack_o,
    output logic [BUS_W-1:0] count_o
);

    if (CNT_W != 2 * BUS_W) begin : g_bad_width
        $error("atomic_counter: CNT_W must equal 2*BUS_W");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [BUS_W-1:0] shadow_q;
    logic [BUS_W-1:0] rd_data;
    logic             ack_q;
    logic [BUS_W-1:0] count_q;

    // Counter wraps naturally modulo 2^CNT_W; reads never stall it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (trig_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Snapshot uses the pre-increment value, matching the low word returned
    // in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
        end else if (req_i && atomic_i) begin
            shadow_q <= cnt_q[CNT_W-1:BUS_W];
        end
    end

    always_comb begin
        rd_data = shadow_q;
        if (atomic_i) begin
            rd_data = cnt_q[BUS_W-1:0];
        end
    end

    // Data holds its last value between requests; ack tracks req one cycle late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ack_q <= req_i;
            if (req_i) begin
                count_q <= rd_data;
            end
        end
    end

    assign ack_o   = ack_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_atomic_counter.sv
module tb_atomic_counter;
    import atomic_counter_pkg::*;

    logic clk;
    logic rst;
    logic trig_i;
    logic req_i;
    logic atomic_i;
    logic ack_o;
    bus_t count_o;

    atomic_counter dut (
        .clk      (clk),
        .rst      (rst),
        .trig_i   (trig_i),
        .req_i    (req_i),
        .atomic_i (atomic_i),
        .ack_o    (ack_o),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic.
    longint unsigned m_cnt;
    longint unsigned m_shadow;
    logic            m_ack;
    longint unsigned m_data;
    logic            s_req;

    int n_checks;
    int n_errs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_shadow = 0;
        m_ack    = 1'b0;
        m_data   = 0;
    endtask

    // Apply one clock edge to the model from the inputs visible at that edge.
    task automatic model_edge();
        s_req = req_i;
        if (!rst) begin
            model_reset();
        end else begin
            if (req_i) begin
                m_ack = 1'b1;
                if (atomic_i) begin
                    m_data   = m_cnt & 64'hFFFF_FFFF;
                    m_shadow = m_cnt >> 32;
                end else begin
                    m_data = m_shadow;
                end
            end else begin
                m_ack = 1'b0;
            end
            if (trig_i) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic compare();
        chk("ack_model", {63'd0, ack_o}, {63'd0, m_ack});
        chk("data_model", {32'd0, count_o}, m_data);
        if (ack_o && !s_req) chk("ack_without_req", {63'd0, ack_o}, 64'd0);
    endtask

    // One clock: edge, model update, sample 1 unit later, return at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic deposit(input cnt_t v);
        force dut.cnt_q = v;
        #1;
        release dut.cnt_q;
        m_cnt = v;
    endtask

    task automatic drive(input logic t, input logic r, input logic a);
        trig_i   = t;
        req_i    = r;
        atomic_i = a;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        s_req    = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("reset_ack", {63'd0, ack_o}, 64'd0);
        chk("reset_data", {32'd0, count_o}, 64'd0);

        // Count five events, then a coherent two-beat read.
        drive(1'b1, 1'b0, 1'b0);
        repeat (5) step();
        drive(1'b0, 1'b1, 1'b1);
        step();
        chk("t1_low_ack", {63'd0, ack_o}, 64'd1);
        chk("t1_low", {32'd0, count_o}, 64'd5);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t1_high_ack", {63'd0, ack_o}, 64'd1);
        chk("t1_high", {32'd0, count_o}, 64'd0);
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("t1_idle_ack", {63'd0, ack_o}, 64'd0);
        chk("t1_idle_hold", {32'd0, count_o}, 64'd0);

        // Carry into the high word between the two beats.
        deposit(64'h0000_0001_FFFF_FFFE);
        drive(1'b1, 1'b1, 1'b1);
        step();
        chk("t2_low", {32'd0, count_o}, 64'hFFFF_FFFE);
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t2_high_shadow", {32'd0, count_o}, 64'd1);
        chk("t2_model_live", m_cnt, 64'h0000_0002_0000_0000);

        // Full wrap to zero.
        deposit(64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1);
        step();
        chk("t3_low", {32'd0, count_o}, 64'd0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t3_high", {32'd0, count_o}, 64'd0);

        // Back-to-back alternating beats while counting from 0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, (i % 2) == 0);
            step();
            chk("t4_b2b_ack", {63'd0, ack_o}, 64'd1);
            chk("t4_b2b_data", {32'd0, count_o}, (i == 2) ? 64'd2 : 64'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("t4_ack_drop", {63'd0, ack_o}, 64'd0);

        // Asynchronous reset between the two beats clears the shadow.
        deposit(64'h0000_0005_0000_0003);
        drive(1'b0, 1'b1, 1'b1);
        step();
        chk("t5_low", {32'd0, count_o}, 64'd3);
        drive(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t5_async_ack", {63'd0, ack_o}, 64'd0);
        chk("t5_async_data", {32'd0, count_o}, 64'd0);
        @(negedge clk);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t5_high_after_rst_ack", {63'd0, ack_o}, 64'd1);
        chk("t5_high_after_rst", {32'd0, count_o}, 64'd0);

        // Randomized traffic against the model, starting from a value near a carry.
        deposit(64'h0000_00A0_FFFF_FFF0);
        for (int i = 0; i < 50; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 1'b0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/atomic_counter.md
Name: atomic_counter

Overview:
- 64-bit free-running event counter, read by a host over a 32-bit bus in two beats.
- The first beat (atomic_i=1) returns the low word and, in the same cycle, snapshots the high word into a shadow register.
- The second beat (atomic_i=0) returns that shadow, so the host always reads a coherent 64-bit value even while counting continues.
- Sits as a memory-mapped statistics counter behind a simple req/ack bus port.

Parameters:
- CNT_W, 64, counter width; must equal 2*BUS_W.
- BUS_W, 32, read data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- trig_i  input  1  count enable; increments the counter by 1 on each clk edge where it is high.
- req_i  input  1  read request, one beat per cycle where it is high.
- atomic_i  input  1  qualifies req_i: 1 = low-word read plus high-word snapshot; 0 = high-word read from the shadow.
- ack_o  output  1  registered acknowledge; count_o is valid while it is high.
- count_o  output  BUS_W  read data.

Behaviour:
- Reset (rst=0, asynchronous): counter=0, shadow=0, count_o=0, ack_o=0. All state is held at these values while rst=0.
- Counter:
  - On posedge clk with trig_i=1: cnt <= cnt+1, modulo 2^64.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - trig_i=0: hold.
- Atomic read (posedge with req_i=1, atomic_i=1):
  - count_o <= cnt[31:0].
  - shadow <= cnt[63:32].
  - ack_o <= 1.
  - Both sampled values are the pre-increment register value, even if trig_i=1 in the same cycle.
- Upper read (posedge with req_i=1, atomic_i=0):
  - count_o <= shadow.
  - ack_o <= 1.
  - Shadow is unchanged.
- Latency: exactly 1 cycle. Data and ack appear on the edge after the request is sampled.
- No request (req_i=0): ack_o <= 0; count_o holds its last value.
- Back-to-back requests are all accepted; ack_o stays high for consecutive cycles. There is no backpressure or busy state.
- Upper read with no prior atomic read returns the current shadow (0 after reset). A stale shadow is returned until the next atomic read.
- Repeated atomic reads overwrite the shadow each time.
- Counting is never stalled by reads.
- Reset asserted mid-sequence: pending ack is dropped and the shadow is cleared. The sequence must be restarted after reset.
- Inputs are synchronous to clk. X on atomic_i is don't-care when req_i=0.

Decomposition:
- Shared package holds:
  - CNT_W and BUS_W constants.
  - A typedef for the 64-bit count.
  - A typedef for the 32-bit bus word.
- Single module; no sub-module is required.
- The counter register, shadow register and read mux are three always_ff/always_comb blocks.

Test Plan:
- Reset, then trig_i=1 for 5 cycles; req_i=1, atomic_i=1 on the next cycle -> one cycle later ack_o=1, count_o=5. Then req_i=1, atomic_i=0 -> ack_o=1, count_o=0.
- Deposit cnt=64'h0000_0001_FFFF_FFFE, hold trig_i=1, atomic read -> count_o=32'hFFFF_FFFE. Upper read two cycles later -> count_o=1, although the live counter is now 64'h0000_0002_0000_0000.
- Deposit cnt=64'hFFFF_FFFF_FFFF_FFFF, one trig_i pulse -> cnt=0. Atomic read then upper read -> 0, 0.
- req_i=1, atomic_i alternating 1/0 for 4 consecutive cycles -> ack_o high for 4 consecutive cycles, 1 cycle delayed; data alternates low word / shadow.
- Assert rst=0 between an atomic read and its upper read -> ack_o=0 and count_o=0 immediately (asynchronous). A subsequent upper read returns 0.
- Random trig_i/req_i/atomic_i for 50 cycles against a reference model -> every ack_o/count_o matches, and no ack occurs without a request one cycle earlier.
